// File: rtl/simon_ctrl_pkg.sv
// Shared constants for the Simon 64/128 block sequencer and its core.
// Holds widths, round count, the z3 key-schedule sequence and FSM state codes.
package simon_ctrl_pkg;

    localparam int unsigned NDefault          = 32;
    localparam int unsigned MDefault          = 4;
    localparam int unsigned BlkW              = 2 * NDefault;
    localparam int unsigned KeyW              = NDefault * MDefault;
    localparam int unsigned TimeoutCycDefault = 1024;
    localparam int unsigned Rounds            = 44;

    // z3 constant sequence, bit i of the sequence stored at index i
    localparam logic [61:0] ZSeq =
        62'b11110000101100111001010001001000000111101001100011010111011011;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StCrst  = 3'd1;
    localparam state_t StStart = 3'd2;
    localparam state_t StWait  = 3'd3;
    localparam state_t StOut   = 3'd4;

endpackage

// File: rtl/simon_core.sv
// Iterative Simon 64/128 core: one round per cycle, key schedule expanded on the fly.
// Protocol: rst clears, an en pulse loads pt/key, done rises after the last round.
module simon_core
    import simon_ctrl_pkg::*;
#(
    parameter int unsigned n = 32,
    parameter int unsigned m = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [n*m-1:0]   key,
    input  logic [2*n-1:0]   pt,
    output logic [2*n-1:0]   ct,
    output logic             done
);

    function automatic logic [n-1:0] rol(input logic [n-1:0] v, input int unsigned s);
        return (v << s) | (v >> (n - s));
    endfunction

    logic [n-1:0] x_q, y_q;
    logic [n-1:0] k_q [m];
    logic [5:0]   round_q;
    logic         run_q, done_q;
    logic [n-1:0] f, kt, k_next;

    // k_q[0] is the current round key, k_q[m-1] the newest expanded word
    always_comb begin
        f      = (rol(x_q, 1) & rol(x_q, 8)) ^ rol(x_q, 2);
        kt     = rol(k_q[m-1], n - 3) ^ k_q[1];
        kt     = kt ^ rol(kt, n - 1);
        k_next = ~k_q[0] ^ kt ^ {{(n-1){1'b0}}, ZSeq[round_q]} ^ {{(n-2){1'b0}}, 2'b11};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            round_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < m; i++) k_q[i] <= '0;
        end else if (en) begin
            x_q     <= pt[2*n-1:n];
            y_q     <= pt[n-1:0];
            round_q <= '0;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < m; i++) k_q[i] <= key[i*n +: n];
        end else if (run_q) begin
            x_q     <= y_q ^ f ^ k_q[0];
            y_q     <= x_q;
            for (int unsigned i = 0; i < m - 1; i++) k_q[i] <= k_q[i+1];
            k_q[m-1] <= k_next;
            round_q  <= round_q + 6'd1;
            if (round_q == 6'(Rounds - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign ct   = {x_q, y_q};
    assign done = done_q;

endmodule

// File: rtl/simon_block_ctrl.sv
// Block sequencer around simon_core: key/IV holding, core pulse protocol, valid/ready output.
// Optional WAIT watchdog with sticky err is enabled by defining SIMON_CTRL_TIMEOUT_EN.
module simon_block_ctrl
    import simon_ctrl_pkg::*;
#(
    parameter int unsigned N           = NDefault,
    parameter int unsigned M           = MDefault,
    parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*M-1:0]   key_in,
    input  logic             key_load,
    input  logic [2*N-1:0]   iv_in,
    input  logic             iv_load,
    input  logic             chain_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_data,
    output logic             busy,
    output logic [15:0]      blk_count,
    output logic             err
);

    state_t           state_q;
    logic [N*M-1:0]   key_q;
    logic [2*N-1:0]   chain_q, pt_q, out_data_q, core_ct;
    logic             out_valid_q;
    logic [15:0]      cnt_q;
    logic             core_rst, core_en, core_done;

`ifdef SIMON_CTRL_TIMEOUT_EN
    logic [31:0]      wd_q;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // A load pulse steals the cycle so key/IV never change under an accepted block
    assign in_ready  = (state_q == StIdle) && !key_load && !iv_load;
    assign busy      = (state_q != StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign blk_count = cnt_q;
    assign core_rst  = rst || (state_q == StCrst);
    assign core_en   = (state_q == StStart);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            chain_q     <= '0;
            pt_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef SIMON_CTRL_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (key_load) key_q <= key_in;
                    if (iv_load) chain_q <= iv_in;
                    if (in_valid && in_ready) begin
                        pt_q    <= in_data ^ (chain_en ? chain_q : '0);
                        state_q <= StCrst;
                    end
                end
                StCrst: state_q <= StStart;
                StStart: begin
                    state_q <= StWait;
`ifdef SIMON_CTRL_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                StWait: begin
                    if (core_done) begin
                        out_data_q  <= core_ct;
                        out_valid_q <= 1'b1;
                        cnt_q       <= cnt_q + 16'd1;
                        state_q     <= StOut;
                    end
`ifdef SIMON_CTRL_TIMEOUT_EN
                    else if (wd_q == 32'(TIMEOUT_CYC - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end
`endif
                end
                StOut: begin
                    if (out_ready) begin
                        chain_q     <= out_data_q;
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    simon_core #(
        .n (N),
        .m (M)
    ) u_core (
        .clk  (clk),
        .rst  (core_rst),
        .en   (core_en),
        .key  (key_q),
        .pt   (pt_q),
        .ct   (core_ct),
        .done (core_done)
    );

endmodule

// File: doc/simon_block_ctrl.md
Name: simon_block_ctrl

Overview:
- Sequencer that streams 64-bit blocks through one instance of the existing simon core (n=32, m=4).
- Holds the key, drives the core's reset/enable pulse protocol and waits for done.
- Captures ciphertext and presents it on a valid/ready output.
- Optional CBC-style chaining: plaintext XOR previous ciphertext/IV. Sits between the host/bus and the cipher datapath.

Parameters:
- N, 32, half block width (core n)
- M, 4, key words (core m)
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- key_in  in  N*M  key value
- key_load  in  1  latch key_in into key_reg; honoured only in IDLE
- iv_in  in  2N  chaining IV
- iv_load  in  1  latch iv_in into chain_reg; honoured only in IDLE
- chain_en  in  1  chaining mode, sampled at block accept
- in_valid  in  1  input block valid
- in_ready  out  1  controller can accept a block
- in_data  in  2N  plaintext block
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  2N  ciphertext block
- busy  out  1  state != IDLE
- blk_count  out  16  completed blocks, wraps at 0xFFFF->0
- err  out  1  sticky watchdog error (0 without the optional feature)

Behaviour:
- Reset values:
  - state=IDLE
  - in_ready=1, out_valid=0, out_data=0, busy=0, blk_count=0, err=0
  - key_reg=0, chain_reg=0
  - core reset asserted
- States:
  - IDLE
  - CRST: core_rst=1 for exactly one cycle
  - START: core_en=1 for exactly one cycle
  - WAIT
  - OUT
- in_ready = (state==IDLE) && !key_load && !iv_load. A load pulse always takes priority that cycle.
- IDLE, on in_valid && in_ready:
  - pt_reg <= in_data ^ (chain_en ? chain_reg : 0); -> CRST.
- CRST -> START.
- START -> WAIT.
- WAIT: on core_done -> OUT.
  - Capture out_data <= core ciphertext.
  - Set out_valid=1, blk_count += 1.
- OUT: hold out_data and out_valid until out_valid && out_ready. In that cycle:
  - chain_reg <= out_data
  - out_valid <= 0
  - go to IDLE
- Core inputs are driven from pt_reg and key_reg, which stay stable from CRST to OUT.
- Core reset input = rst || (state==CRST).
- Latency: accept -> out_valid = 3 + core latency. Must be identical for every block. Back-to-back blocks need at least 1 IDLE cycle between them.
- key_load/iv_load outside IDLE are ignored: no effect, no error.
- chain_reg is updated on every accepted output, whether or not chain_en is set. An iv_load in IDLE overrides it.
- rst mid-block: next cycle IDLE, out_valid=0, pending block discarded, key_reg/chain_reg/blk_count/err cleared.
- core_done arriving outside WAIT is ignored.

Optional Feature:
- Macro: SIMON_CTRL_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYC without core_done: err<=1 (sticky until rst), state->IDLE, no output produced, blk_count unchanged.
- When undefined:
  - No counter; WAIT waits indefinitely.
  - err is tied to 0.

Decomposition:
- Package simon_ctrl_pkg:
  - state enum (IDLE, CRST, START, WAIT, OUT)
  - block/key width constants derived from N, M
  - default TIMEOUT_CYC
- Sub-module: the existing simon core, instantiated once with (.n(N), .m(M)). No new sub-modules.

Test Plan:
- Basic vector: key_load key=1b1a1918131211100b0a090803020100, chain_en=0, in_data=656b696c20646e75 -> out_data=44c8fc20b9dfa07a, blk_count=1.
- Chaining: key=FEDCBA98765432100123456789ABCDEF, iv_load iv=0, chain_en=1.
  - Blocks in_data=1234567890ABCDEF, then 0, then 0 -> outputs 34BE744934FABB4E, 823A057D5B933604, 06372B3E88230685.
- Backpressure: key=0123456789ABCDEF0123456789ABCDEF, in=FEDCBA9876543210, out_ready low 20 cycles -> out_valid and out_data=E0EEA3F009ED2BC7 held stable; in_ready=0 throughout; one transfer on release.
- Load priority/ignore:
  - key_load and in_valid in the same IDLE cycle -> in_ready=0, key latched, block accepted next cycle.
  - key_load during WAIT -> ignored; the result uses the old key.
- Reset mid-operation: rst in WAIT -> out_valid=0, busy=0, blk_count=0 next cycle. A subsequent block with key=CAFEBABE x4, in=CAFEBABECAFEBABE -> 5DB4EBCDBC6188DE.
- (SIMON_CTRL_TIMEOUT_EN, TIMEOUT_CYC=4) core_done forced low -> err=1, state returns to IDLE, no out_valid.
